// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges a single-word request port onto an asynchronous SRAM.
// Each request word (BEATS*SRAM_DW bits) is moved as BEATS consecutive SRAM
// beats, lowest lane first. Each beat holds address, write enable and write
// data stable for WAIT_CYCLES+1 cycles.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   wr_en_i, rd_en_i : request strobes, held until ready_o=1 (write wins)
//   address_i        : byte address; BASE_ADDR maps to SRAM word 0
//   wdata_i          : write word
//   rdata_o          : registered read word, changes only on a completed read
//   ready_o          : low while a request is pending or being served
//   sram_addr_o      : registered SRAM word address
//   sram_we_n_o      : registered SRAM write enable, active low
//   sram_dq_io       : SRAM data bus, driven only during write beats
module sram_ctrl #(
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned BEATS       = 2,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic                       rd_en_i,
    input  logic [31:0]                address_i,
    input  logic [BEATS*SRAM_DW-1:0]   wdata_i,
    output logic [BEATS*SRAM_DW-1:0]   rdata_o,
    output logic                       ready_o,
    output logic [SRAM_AW-1:0]         sram_addr_o,
    output logic                       sram_we_n_o,
    inout  wire  [SRAM_DW-1:0]         sram_dq_io
);
    localparam int unsigned DW      = BEATS * SRAM_DW;
    localparam int unsigned BYTE_SH = $clog2(DW / 8);
    localparam int unsigned BEAT_SH = $clog2(BEATS);
    localparam int unsigned BW      = (BEATS > 1) ? BEAT_SH : 1;
    localparam int unsigned WW      = $clog2(WAIT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                          state_q, state_d;
    logic                            op_wr_q, op_wr_d;
    logic [31:0]                     word_q, word_d;
    logic [BEATS-1:0][SRAM_DW-1:0]   wdata_q, wdata_d;
    logic [BEATS-1:0][SRAM_DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]                   rdata_q, rdata_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic [WW-1:0]                   wait_q, wait_d;
    logic [SRAM_AW-1:0]              addr_q, addr_d;
    logic                            we_n_q, we_n_d;
    logic [31:0]                     word_in;

    // Word index wraps modulo 2^32, so addresses below BASE_ADDR land at the
    // top of the index space rather than being rejected.
    assign word_in = (address_i - BASE_ADDR) >> BYTE_SH;

    function automatic logic [SRAM_AW-1:0] beat_addr(input logic [31:0] word,
                                                     input logic [BW-1:0] beat);
        logic [31:0] a;
        a = (word << BEAT_SH) + 32'(beat);
        return a[SRAM_AW-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        we_n_d   = we_n_q;
        ready_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = !(wr_en_i || rd_en_i);
                if (wr_en_i || rd_en_i) begin
                    state_d = ACCESS;
                    op_wr_d = wr_en_i;
                    word_d  = word_in;
                    wdata_d = wdata_i;
                    beat_d  = '0;
                    wait_d  = '0;
                    addr_d  = beat_addr(word_in, '0);
                    we_n_d  = !wr_en_i;
                end
            end
            ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    wait_d = '0;
                    // Sample the bus on the edge that closes the beat.
                    if (!op_wr_q) shadow_d[beat_q] = sram_dq_io;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        beat_d  = '0;
                        we_n_d  = 1'b1;
                        // Use shadow_d so the final lane captured on this
                        // same edge is already part of the word.
                        if (!op_wr_q) rdata_d = shadow_d;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = beat_addr(word_q, beat_q + 1'b1);
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_wr_q  <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            addr_q   <= '0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_we_n_o = we_n_q;
    // Bus released as soon as reset lands, since state_q clears asynchronously.
    assign sram_dq_io  = (state_q == ACCESS && op_wr_q) ? wdata_q[beat_q] : 'z;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized transactions on the default configuration checked
// each cycle against a transaction-level model (reference memory, expected
// beat address/data by cycle index), plus literal pins for the write/read,
// mapping, simultaneous-request, reset-abort and WAIT_CYCLES=3 cases.
module tb_sram_ctrl;
    localparam int L = 4;   // BEATS*(WAIT_CYCLES+1) for the main instance

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata, rdata;
    logic        ready, we_n;
    logic [17:0] sram_addr;
    wire  [15:0] dq;

    logic        wr2, rd2, ready2, we2;
    logic [31:0] a2, wd2, rdata2;
    logic [17:0] sa2;
    wire  [15:0] dq2;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .address_i(address), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
        .sram_addr_o(sram_addr), .sram_we_n_o(we_n), .sram_dq_io(dq)
    );

    sram_ctrl #(.WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .wr_en_i(wr2), .rd_en_i(rd2),
        .address_i(a2), .wdata_i(wd2), .rdata_o(rdata2), .ready_o(ready2),
        .sram_addr_o(sa2), .sram_we_n_o(we2), .sram_dq_io(dq2)
    );

    // SRAM devices on the buses
    logic [15:0] mem     [0:262143];
    logic [15:0] ref_mem [0:262143];
    logic [15:0] mem2    [0:15];
    assign dq  = we_n ? mem[sram_addr] : 'z;
    assign dq2 = we2 ? mem2[sa2[3:0]] : 'z;
    always @(posedge clk) if (!we_n) mem[sram_addr] <= dq;
    always @(posedge clk) if (!we2) mem2[sa2[3:0]] <= dq2;

    function automatic logic [15:0] pat(input int i);
        logic [31:0] t;
        t = i * 32'h9E37 + 32'h1234;
        return t[15:0];
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state for the transaction in flight
    int          cyc = -1;       // -1: idle, 0..L-1: access cycle, L: done cycle
    bit          cmp_on = 1'b0;
    bit          t_wr;
    logic [31:0] t_word, t_data;
    logic [31:0] m_rdata = '0;
    int          n_rl, n_wl;

    function automatic logic [17:0] exp_addr(input logic [31:0] word, input int k);
        logic [31:0] e;
        e = word * 2 + k;
        return e[17:0];
    endfunction

    always @(negedge clk) begin : cmp
        int b;
        if (!rst && cmp_on) begin
            if (cyc < 0) begin
                chk("ready_idle", 32'(ready), 32'(!(wr_en || rd_en)));
                chk("we_n_idle", 32'(we_n), 32'd1);
            end else if (cyc < L) begin
                b = cyc / 2;
                chk("ready_busy", 32'(ready), 32'd0);
                chk("we_n_beat", 32'(we_n), 32'(!t_wr));
                chk("addr_beat", 32'(sram_addr), 32'(exp_addr(t_word, b)));
                if (t_wr) chk("dq_beat", 32'(dq), (b == 0) ? 32'(t_data[15:0]) : 32'(t_data[31:16]));
            end else begin
                chk("ready_done", 32'(ready), 32'd1);
                chk("we_n_done", 32'(we_n), 32'd1);
                if (t_wr) begin
                    chk("mem_lane0", 32'(mem[exp_addr(t_word, 0)]), 32'(t_data[15:0]));
                    chk("mem_lane1", 32'(mem[exp_addr(t_word, 1)]), 32'(t_data[31:16]));
                end
            end
            chk("rdata", rdata, m_rdata);
        end
    end

    always @(negedge clk) if (cyc >= 0) begin
        if (!ready) n_rl++;
        if (!we_n) n_wl++;
    end

    // Entered one step after a rising edge; leaves one step after the edge
    // that ends the done cycle, with the request dropped.
    task automatic txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        t_wr   = w;
        t_word = (a - 32'd1024) >> 2;
        t_data = d;
        wr_en = w; rd_en = r; address = a; wdata = d;
        cyc = -1;
        @(posedge clk); #1;
        for (int c = 0; c <= L; c++) begin
            cyc = c;
            if (c == L) begin
                if (w) begin
                    ref_mem[exp_addr(t_word, 0)] = d[15:0];
                    ref_mem[exp_addr(t_word, 1)] = d[31:16];
                end else begin
                    m_rdata = {ref_mem[exp_addr(t_word, 1)], ref_mem[exp_addr(t_word, 0)]};
                end
            end
            address = $urandom;
            wdata   = $urandom;
            @(posedge clk); #1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        cyc = -1;
    endtask

    task automatic v6(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        int lo;
        wr2 = w; rd2 = !w; a2 = a; wd2 = d;
        @(posedge clk);
        lo = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!ready2) lo++;
            chk("v6_addr", 32'(sa2), 32'(8 + c / 4));
            chk("v6_we_n", 32'(we2), 32'(!w));
        end
        @(negedge clk);
        chk("v6_ready_done", 32'(ready2), 32'd1);
        chk("v6_ready_low_cycles", lo, 8);
        if (!w) chk("v6_rdata", rdata2, exp_rd);
        @(posedge clk); #1;
        wr2 = 1'b0; rd2 = 1'b0;
    endtask

    initial begin
        logic [15:0] old5;
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 262144; i++) begin
            mem[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        for (int i = 0; i < 16; i++) mem2[i] = '0;
        rst = 1'b1;
        wr_en = 0; rd_en = 0; address = '0; wdata = '0;
        wr2 = 0; rd2 = 0; a2 = '0; wd2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_on = 1'b1;
        @(posedge clk); #1;

        // V1 write, V2 read-back
        n_rl = 0; n_wl = 0;
        txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        chk("v1_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("v1_mem1", 32'(mem[1]), 32'h0000DEAD);
        chk("v1_ready_low", n_rl, 4);
        chk("v1_we_low", n_wl, 4);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        chk("v2_rdata", rdata, 32'hDEADBEEF);

        // V3 mapping, low address bits ignored
        txn(1'b1, 1'b0, 32'd1036, 32'hA1A2B1B2);
        chk("v3_mem6", 32'(mem[6]), 32'h0000B1B2);
        chk("v3_mem7", 32'(mem[7]), 32'h0000A1A2);
        txn(1'b1, 1'b0, 32'd1038, 32'hC1C2D1D2);
        chk("v3b_mem6", 32'(mem[6]), 32'h0000D1D2);
        chk("v3b_mem7", 32'(mem[7]), 32'h0000C1C2);

        // V4 simultaneous request behaves as a write
        txn(1'b1, 1'b1, 32'd1028, 32'h12345678);
        chk("v4_mem2", 32'(mem[2]), 32'h00005678);
        chk("v4_mem3", 32'(mem[3]), 32'h00001234);
        chk("v4_rdata_kept", rdata, 32'hDEADBEEF);

        // Address below base wraps to the top of the SRAM
        txn(1'b1, 1'b0, 32'd1020, 32'h0BADF00D);
        chk("wrap_lo", 32'(mem[18'h3FFFE]), 32'h0000F00D);
        chk("wrap_hi", 32'(mem[18'h3FFFF]), 32'h00000BAD);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                a = 32'd1024 - 32'($urandom_range(1, 8) * 4) + 32'($urandom_range(0, 3));
            else
                a = 32'd1024 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            txn(op == 0 || op == 3, op != 0, a, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // V5 reset during beat 1 of a write
        cmp_on = 1'b0;
        old5 = mem[5];
        wr_en = 1'b1; address = 32'd1032; wdata = 32'h77776666;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        chk("v5_we_n_beat1", 32'(we_n), 32'd0);
        chk("v5_addr_beat1", 32'(sram_addr), 32'd5);
        rst = 1'b1; wr_en = 1'b0;
        #1;
        chk("v5_we_n_rst", 32'(we_n), 32'd1);
        chk("v5_rdata_rst", rdata, 32'd0);
        chk("v5_addr_rst", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("v5_ready_after", 32'(ready), 32'd1);
        chk("v5_mem4", 32'(mem[4]), 32'h00006666);
        chk("v5_mem5", 32'(mem[5]), 32'(old5));
        ref_mem[4] = 16'h6666;
        m_rdata = '0;
        @(posedge clk); #1;
        cmp_on = 1'b1;
        txn(1'b0, 1'b1, 32'd1032, 32'h0);
        chk("v5_readback", rdata, {old5, 16'h6666});

        // V6 WAIT_CYCLES=3 instance
        v6(1'b1, 32'd1040, 32'hCAFEF00D, 32'h0);
        chk("v6_mem8", 32'(mem2[8]), 32'h0000F00D);
        v6(1'b0, 32'd1040, 32'h0, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter SRAM_DW, default 16, SRAM data bus width in bits.
REQ-002 Parameter SRAM_AW, default 18, SRAM address width in bits.
REQ-003 Parameter BEATS, default 2, SRAM beats per request word; request word width is DW = BEATS*SRAM_DW; BEATS is a power of two and at least 1.
REQ-004 Parameter WAIT_CYCLES, default 1, extra cycles per beat; minimum 1.
REQ-005 Parameter BASE_ADDR, default 1024, byte address mapped to SRAM word 0.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  write request, held by requester until ready=1.
REQ-009 rd_en  input  1  read request, held by requester until ready=1.
REQ-010 address  input  32  byte address of request.
REQ-011 wdata  input  DW  write data.
REQ-012 rdata  output  DW  read data, registered.
REQ-013 ready  output  1  low while a request is pending or in progress; requester stalls on ready=0.
REQ-014 SRAM_ADDR  output  SRAM_AW  SRAM word address, registered.
REQ-015 SRAM_WE_N  output  1  SRAM write enable, active low, registered.
REQ-016 SRAM_DQ  inout  SRAM_DW  SRAM data bus, driven only during write beats, else high-Z.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; reset state IDLE.
REQ-018 ready = 1 in DONE; in IDLE, ready = NOT(wr_en OR rd_en); in ACCESS, ready = 0.
REQ-019 IDLE with wr_en or rd_en at a rising edge: latch address, wdata and operation, clear beat and wait counters, enter ACCESS.
REQ-020 wr_en and rd_en both high: the request is a write; no read occurs.
REQ-021 Word index = (address - BASE_ADDR) >> log2(DW/8), modulo 2^32; the low address bits below the word boundary are ignored.
REQ-022 Beat k (k = 0..BEATS-1, ascending) uses SRAM_ADDR = (word_index*BEATS + k), truncated to SRAM_AW bits.
REQ-023 Each beat lasts WAIT_CYCLES+1 cycles; SRAM_ADDR is stable for the whole beat.
REQ-024 Write beat k: SRAM_WE_N = 0 and SRAM_DQ = wdata[(k+1)*SRAM_DW-1 : k*SRAM_DW] for the whole beat.
REQ-025 Read beat k: SRAM_WE_N = 1 and SRAM_DQ is high-Z. On the rising edge ending the beat's last cycle, SRAM_DQ is captured into a shadow register at the lane for beat k.
REQ-026 After the last beat, the FSM enters DONE. On a read, rdata is loaded from the shadow register when entering DONE. SRAM_WE_N returns to 1 and SRAM_DQ to high-Z.
REQ-027 DONE lasts exactly one cycle with ready = 1, then the FSM returns to IDLE unconditionally.
REQ-028 Request-to-ready latency is BEATS*(WAIT_CYCLES+1) cycles of ready = 0, followed by one DONE cycle.
REQ-029 rdata holds its value across writes and idle cycles; only a completed read changes it.
REQ-030 Changes to wr_en, rd_en, address and wdata during ACCESS are ignored.
REQ-031 Beat and wait counters wrap to zero at their terminal values; there is no carry into unused bits.

Reset
REQ-032 rst high at any time, including mid-beat: state=IDLE, SRAM_WE_N=1, SRAM_ADDR=0, rdata=0, SRAM_DQ high-Z, counters=0, shadow register=0.
REQ-033 A transaction aborted by reset is not resumed; partial SRAM writes already completed stay in SRAM.
REQ-034 After reset release with no request, ready = 1.

Verification
Defaults for all scenarios except V6: SRAM_DW=16, BEATS=2, WAIT_CYCLES=1, BASE_ADDR=1024.
REQ-035 V1, write: wr_en with address=1024, wdata=0xDEADBEEF -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD, SRAM_WE_N low 4 cycles, ready low 4 cycles then high 1 cycle.
REQ-036 V2, read-back: rd_en with address=1024 after V1 -> rdata=0xDEADBEEF in the DONE cycle; SRAM_DQ never driven by sram_ctrl.
REQ-037 V3, address mapping: write with address=1036 (and with 1038) -> SRAM_ADDR sequence 6 then 7; low bits ignored.
REQ-038 V4, simultaneous requests: wr_en=rd_en=1, address=1028, wdata=0x12345678 -> SRAM[2]=0x5678, SRAM[3]=0x1234, rdata unchanged.
REQ-039 V5, reset mid-write: rst asserted in beat 1 of a write -> same cycle SRAM_WE_N=1, SRAM_DQ high-Z, rdata=0; after release ready=1; SRAM[beat-0 address] written, beat-1 address unchanged.
REQ-040 V6, WAIT_CYCLES=3: read -> ready low 8 cycles; each SRAM_ADDR held 4 cycles; rdata correct.
